i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx.sv | 130 +++++++++++++
 tb/tb_i2s_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/din on in_mclk and
// emits one left/right word pair per frame with a strobe.
module i2s_rx #(
    parameter int G_BITS = 16
) (
    input  logic              in_mclk,
    input  logic              in_reset,
    input  logic              in_sclk,
    input  logic              in_lrclk,
    input  logic              in_din,
    output logic [G_BITS-1:0] out_frame_1,
    output logic [G_BITS-1:0] out_frame_2,
    output logic              out_frame_strobe,
    output logic              out_locked,
    output logic              out_len_error
);

    localparam int CW = $clog2(G_BITS + 2);
    localparam logic [CW-1:0] C_MAX  = CW'(G_BITS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(G_BITS - 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0] sclk_sr, lrclk_sr, din_sr;
    logic       sclk_q, ws_prev;
    logic       sclk_s, lrclk_s, din_s;
    logic       bit_ev, ws_chg;

    logic [G_BITS-1:0] shift, shift_nxt, hold;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              short_word;

    logic lock_ev, close_left, close_right, shift_en;

    assign sclk_s  = sclk_sr[1];
    assign lrclk_s = lrclk_sr[1];
    assign din_s   = din_sr[1];
    assign bit_ev  = sclk_s & ~sclk_q;
    assign ws_chg  = bit_ev & (lrclk_s != ws_prev);

    always_ff @(posedge in_mclk or posedge in_reset) begin
        if (in_reset) begin
            sclk_sr  <= '0;
            lrclk_sr <= '0;
            din_sr   <= '0;
            sclk_q   <= 1'b0;
            ws_prev  <= 1'b0;
        end else begin
            sclk_sr  <= {sclk_sr[0], in_sclk};
            lrclk_sr <= {lrclk_sr[0], in_lrclk};
            din_sr   <= {din_sr[0], in_din};
            sclk_q   <= sclk_s;
            if (bit_ev) ws_prev <= lrclk_s;
        end
    end

    // Current bit lands at G_BITS-1-cnt; bits past the word width are dropped.
    always_comb begin
        shift_nxt = shift;
        for (int i = 0; i < G_BITS; i++) begin
            if (cnt == CW'(G_BITS - 1 - i)) shift_nxt[i] = din_s;
        end
        cnt_nxt    = (cnt == C_MAX) ? cnt : cnt + CW'(1);
        short_word = cnt < C_LAST;
    end

    always_ff @(posedge in_mclk or posedge in_reset) begin
        if (in_reset) state <= SYNC;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SYNC:    if (bit_ev && ws_prev && !lrclk_s) state_nxt = LEFT;
            LEFT:    if (ws_chg) state_nxt = RIGHT;
            RIGHT:   if (ws_chg) state_nxt = LEFT;
            default: state_nxt = SYNC;
        endcase
    end

    always_comb begin
        lock_ev     = (state == SYNC) & bit_ev & ws_prev & ~lrclk_s;
        close_left  = (state == LEFT) & ws_chg;
        close_right = (state == RIGHT) & ws_chg;
        shift_en    = (state != SYNC) & bit_ev & ~ws_chg;
    end

    always_ff @(posedge in_mclk or posedge in_reset) begin
        if (in_reset) begin
            shift            <= '0;
            cnt              <= '0;
            hold             <= '0;
            out_frame_1      <= '0;
            out_frame_2      <= '0;
            out_frame_strobe <= 1'b0;
            out_locked       <= 1'b0;
            out_len_error    <= 1'b0;
        end else begin
            out_frame_strobe <= 1'b0;
            if (lock_ev) begin
                shift      <= '0;
                cnt        <= '0;
                out_locked <= 1'b1;
            end else if (close_left) begin
                hold  <= shift_nxt;
                shift <= '0;
                cnt   <= '0;
                if (short_word) out_len_error <= 1'b1;
            end else if (close_right) begin
                out_frame_1      <= hold;
                out_frame_2      <= shift_nxt;
                out_frame_strobe <= 1'b1;
                shift            <= '0;
                cnt              <= '0;
                if (short_word) out_len_error <= 1'b1;
            end else if (shift_en) begin
                shift <= shift_nxt;
                cnt   <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: serial I2S generator, word-level model
// feeding a scoreboard queue, and a strobe-driven monitor.
module tb_i2s_rx;

    localparam int G = 16;

    logic         in_mclk = 1'b0;
    logic         in_reset = 1'b0;
    logic         in_sclk = 1'b0;
    logic         in_lrclk = 1'b0;
    logic         in_din = 1'b0;
    logic [G-1:0] out_frame_1, out_frame_2;
    logic         out_frame_strobe, out_locked, out_len_error;

    i2s_rx #(.G_BITS(G)) dut (
        .in_mclk          (in_mclk),
        .in_reset         (in_reset),
        .in_sclk          (in_sclk),
        .in_lrclk         (in_lrclk),
        .in_din           (in_din),
        .out_frame_1      (out_frame_1),
        .out_frame_2      (out_frame_2),
        .out_frame_strobe (out_frame_strobe),
        .out_locked       (out_locked),
        .out_len_error    (out_len_error)
    );

    always #5 in_mclk = ~in_mclk;

    typedef struct packed {
        logic [G-1:0] f1;
        logic [G-1:0] f2;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors = 0;
    int   strobes = 0;

    // word-level model state
    logic         m_locked = 1'b0;
    logic         m_prev_ws = 1'b0;
    logic         m_err = 1'b0;
    logic         m_left_ok = 1'b0;
    logic [G-1:0] m_left = '0;
    logic         tx_bit = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [G-1:0] align(input logic [31:0] d, input int w);
        logic [31:0] m;
        m = (w >= 32) ? d : (d & ((32'd1 << w) - 32'd1));
        if (w >= G) return G'(m >> (w - G));
        else        return G'(m << (G - w));
    endfunction

    task automatic slot(input logic ws, input logic d);
        in_lrclk = ws;
        in_din   = d;
        #40 in_sclk = 1'b1;
        #40 in_sclk = 1'b0;
    endtask

    task automatic send_word(input logic ch, input logic [31:0] data,
                             input int w);
        if (!m_locked && m_prev_ws && !ch) m_locked = 1'b1;
        if (m_locked && w < G) m_err = 1'b1;
        if (!ch) begin
            m_left    = align(data, w);
            m_left_ok = m_locked;
        end else begin
            if (m_left_ok) q.push_back('{m_left, align(data, w), m_err});
            m_left_ok = 1'b0;
        end
        m_prev_ws = ch;
        for (int j = 0; j < w; j++) begin
            slot(ch, tx_bit);
            tx_bit = data[w-1-j];
        end
    endtask

    task automatic model_reset();
        m_locked  = 1'b0;
        m_prev_ws = 1'b0;
        m_err     = 1'b0;
        m_left_ok = 1'b0;
    endtask

    logic prev_strobe = 1'b0;
    always @(negedge in_mclk) begin
        exp_t e;
        if (out_frame_strobe) begin
            strobes++;
            chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_strobe got=1 exp=0");
            end else begin
                e = q.pop_front();
                chk("frame_1", 32'(out_frame_1), 32'(e.f1));
                chk("frame_2", 32'(out_frame_2), 32'(e.f2));
                chk("len_error", 32'(out_len_error), 32'(e.err));
                chk("locked_at_strobe", 32'(out_locked), 32'd1);
            end
        end
        prev_strobe = out_frame_strobe;
    end

    task automatic check_idle(input string nm);
        chk({nm, "_f1"}, 32'(out_frame_1), 32'd0);
        chk({nm, "_f2"}, 32'(out_frame_2), 32'd0);
        chk({nm, "_stb"}, 32'(out_frame_strobe), 32'd0);
        chk({nm, "_lock"}, 32'(out_locked), 32'd0);
        chk({nm, "_err"}, 32'(out_len_error), 32'd0);
    endtask

    initial begin
        #3 in_reset = 1'b1;
        repeat (4) @(posedge in_mclk);
        #1 check_idle("reset");
        in_reset = 1'b0;
        model_reset();
        repeat (4) @(posedge in_mclk);

        // enter mid-right-channel: partial word must not produce a frame
        send_word(1'b1, 32'($urandom), 7);
        chk("unlocked_mid_right", 32'(out_locked), 32'd0);
        send_word(1'b0, 32'hA5C3, 16);
        chk("locked_after_ws", 32'(out_locked), 32'd1);
        send_word(1'b1, 32'h1234, 16);

        // long words truncated to the MSBs
        send_word(1'b0, 32'hABCDEF, 24);
        send_word(1'b1, 32'h123456, 24);

        // short words left-aligned, sticky error
        send_word(1'b0, 32'hFFF, 12);
        send_word(1'b1, 32'h801, 12);

        for (int i = 0; i < 100; i++) begin
            send_word(1'b0, 32'(2 * i + 16'h0100), 16);
            send_word(1'b1, 32'(2 * i + 16'h0101), 16);
        end

        for (int i = 0; i < 12; i++) begin
            send_word(1'b0, $urandom, int'($urandom_range(8, 24)));
            send_word(1'b1, $urandom, int'($urandom_range(8, 24)));
        end

        // part of a left word, then reset in the middle of it
        send_word(1'b0, 32'h5555, 5);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("err_sticky", 32'(out_len_error), 32'd1);
        @(posedge in_mclk);
        #1 in_reset = 1'b1;
        #1 check_idle("midreset");
        repeat (3) @(posedge in_mclk);
        #1 in_reset = 1'b0;
        model_reset();

        send_word(1'b1, 32'($urandom), 16);
        chk("relock_pending", 32'(out_locked), 32'd0);
        send_word(1'b0, 32'hC0DE, 16);
        send_word(1'b1, 32'hBEEF, 16);
        send_word(1'b0, 32'h0, 2);
        repeat (40) @(posedge in_mclk);

        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("strobe_count", 32'(strobes), 32'd116);
        chk("final_locked", 32'(out_locked), 32'd1);
        chk("final_f1", 32'(out_frame_1), 32'hC0DE);
        chk("final_f2", 32'(out_frame_2), 32'hBEEF);
        chk("final_err", 32'(out_len_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
